// File: rtl/rom_word_reader.sv
// Purpose: walks NUM_WORDS words of the synchronous program ROM from BASE_ADDR and streams each word with its byte address.
// Latency: the first word is valid 2 cycles after start; each word takes 3 cycles (ISSUE, CAPT, SEND) with out_ready high.
// Backpressure: stalls in SEND with every output held while out_ready is low; abort cancels from any state on the next edge.
module rom_word_reader #(
    parameter int unsigned NUM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [31:0] out_addr,
    output logic        out_last
);

    localparam int unsigned      CNT_W     = $clog2(NUM_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_WORDS - 1);
    // Force word alignment so the low address bits can never be non-zero
    localparam logic [31:0]      BASE_WORD = {BASE_ADDR[31:2], 2'b00};

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPT,
        SEND
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;

    // Sweep FSM with all outputs registered; abort wins over every other input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_addr  <= BASE_WORD;
            out_valid <= 1'b0;
            out_data  <= 32'h0;
            out_addr  <= 32'h0;
            out_last  <= 1'b0;
        end else begin
            // done is a single-cycle pulse unless the final handshake sets it below
            done <= 1'b0;
            if (abort) begin
                // Cancel without a done pulse; mem_addr keeps its value
                state     <= IDLE;
                busy      <= 1'b0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            mem_addr <= BASE_WORD;
                            count    <= '0;
                            busy     <= 1'b1;
                            state    <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        // ROM samples mem_addr on this edge; data shows up next cycle
                        state <= CAPT;
                    end
                    CAPT: begin
                        out_data  <= mem_rdata;
                        out_addr  <= mem_addr;
                        out_valid <= 1'b1;
                        out_last  <= (count == LAST_CNT);
                        state     <= SEND;
                    end
                    SEND: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            if (count == LAST_CNT) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                // 32-bit wrap is intended for sweeps near the top of the map
                                mem_addr <= mem_addr + 32'd4;
                                count    <= count + 1'b1;
                                state    <= ISSUE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_word_reader.sv
// Bench for rom_word_reader: a 4-word and a 1024-word instance driven from one clock,
// each checked every cycle against a transaction-level model, plus directed literal checks.
module tb_rom_word_reader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          N0   = 4;
    localparam int          N1   = 1024;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0]       start_v, abort_v, ready_v;
    logic [1:0]       busy_v, done_v, valid_v, last_v;
    logic [1:0][31:0] mem_addr_v, rdata_v, data_v, oaddr_v;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rom_word_reader #(.NUM_WORDS(N0), .BASE_ADDR(BASE)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .mem_addr(mem_addr_v[0]), .mem_rdata(rdata_v[0]),
        .out_valid(valid_v[0]), .out_ready(ready_v[0]), .out_data(data_v[0]),
        .out_addr(oaddr_v[0]), .out_last(last_v[0])
    );

    rom_word_reader #(.NUM_WORDS(N1), .BASE_ADDR(BASE)) u_dut_big (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .mem_addr(mem_addr_v[1]), .mem_rdata(rdata_v[1]),
        .out_valid(valid_v[1]), .out_ready(ready_v[1]), .out_data(data_v[1]),
        .out_addr(oaddr_v[1]), .out_last(last_v[1])
    );

    // ROM image: word i holds A500_0000 + i
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'hA500_0000 + {2'b00, a[31:2]};
    endfunction

    // Synchronous ROM, one cycle of read latency
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) rdata_v[k] <= rom_word(mem_addr_v[k]);
    end

    // Transaction-level model: a sweep is N words, each becoming visible two edges after
    // its request, leaving on a handshake; done follows the last handshake.
    typedef struct packed {
        logic        busy;
        logic        done;
        logic        valid;
        int          idx;
        int          delay;
        logic [31:0] addr;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.busy = 1'b0; r.done = 1'b0; r.valid = 1'b0;
        r.idx = 0; r.delay = 0; r.addr = BASE;
        return r;
    endfunction

    function automatic mdl_t step(input mdl_t m, input int n, input logic st, input logic ab, input logic rdy);
        mdl_t r = m;
        r.done = 1'b0;
        if (ab) begin
            r.busy = 1'b0; r.valid = 1'b0;
        end else if (!m.busy) begin
            if (st) begin
                r.busy = 1'b1; r.idx = 0; r.addr = BASE; r.delay = 2;
            end
        end else if (m.valid) begin
            if (rdy) begin
                r.valid = 1'b0;
                if (m.idx == n - 1) begin
                    r.busy = 1'b0; r.done = 1'b1;
                end else begin
                    r.idx = m.idx + 1; r.addr = m.addr + 32'd4; r.delay = 2;
                end
            end
        end else begin
            r.delay = m.delay - 1;
            if (r.delay == 0) r.valid = 1'b1;
        end
        return r;
    endfunction

    mdl_t mdl [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl[0] <= mdl_reset();
            mdl[1] <= mdl_reset();
        end else begin
            mdl[0] <= step(mdl[0], N0, start_v[0], abort_v[0], ready_v[0]);
            mdl[1] <= step(mdl[1], N1, start_v[1], abort_v[1], ready_v[1]);
        end
    end

    // Handshake / done log, sampled at the edge where they take effect
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] addr;
        logic        last;
        int          cyc;
    } hs_t;

    hs_t         hs_q[$];
    int          done_q[$];
    int          cyc = 0;
    int          big_hs = 0;
    int          big_done = 0;
    logic [31:0] big_last_addr = 32'h0;
    logic        big_last_last = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (valid_v[0] && ready_v[0]) hs_q.push_back({data_v[0], oaddr_v[0], last_v[0], cyc});
            if (done_v[0]) done_q.push_back(cyc);
            if (valid_v[1] && ready_v[1]) begin
                big_hs        <= big_hs + 1;
                big_last_addr <= oaddr_v[1];
                big_last_last <= last_v[1];
            end
            if (done_v[1]) big_done <= big_done + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset(input int k);
        check($sformatf("rst_busy%0d", k), busy_v[k], 1'b0);
        check($sformatf("rst_done%0d", k), done_v[k], 1'b0);
        check($sformatf("rst_valid%0d", k), valid_v[k], 1'b0);
        check($sformatf("rst_last%0d", k), last_v[k], 1'b0);
        check($sformatf("rst_data%0d", k), data_v[k], 32'h0);
        check($sformatf("rst_oaddr%0d", k), oaddr_v[k], 32'h0);
        check($sformatf("rst_maddr%0d", k), mem_addr_v[k], BASE);
    endtask

    task automatic pulse_start0();
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
    endtask

    task automatic wait_done0(input int budget);
        int n = 0;
        while (!done_v[0] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_wait", done_v[0], 1'b1);
    endtask

    task automatic wait_word0(input logic [31:0] a, input int budget);
        int n = 0;
        while (!(valid_v[0] && oaddr_v[0] == a) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("word_wait", valid_v[0], 1'b1);
    endtask

    int s, bi, bd, n;

    initial begin
        start_v = '0; abort_v = '0; ready_v = '0;

        // Per-cycle comparison against the model for both instances
        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    for (int k = 0; k < 2; k++) begin
                        check($sformatf("busy%0d", k), busy_v[k], mdl[k].busy);
                        check($sformatf("done%0d", k), done_v[k], mdl[k].done);
                        check($sformatf("valid%0d", k), valid_v[k], mdl[k].valid);
                        check($sformatf("mem_addr%0d", k), mem_addr_v[k], mdl[k].addr);
                        check($sformatf("rom_range%0d", k), mem_addr_v[k] < 32'h1000, 1'b1);
                        if (mdl[k].valid) begin
                            check($sformatf("data%0d", k), data_v[k], rom_word(mdl[k].addr));
                            check($sformatf("oaddr%0d", k), oaddr_v[k], mdl[k].addr);
                            check($sformatf("last%0d", k), last_v[k],
                                  mdl[k].idx == ((k == 0) ? N0 : N1) - 1);
                        end
                    end
                end
            end
        join_none

        // Reset values
        #12;
        check_reset(0);
        check_reset(1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Kick off the 1024-word sweep; it runs alongside the small-instance tests
        ready_v[1] = 1'b1;
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;

        // Plain sweep, out_ready high: 3 cycles per word, done 1 cycle after last handshake
        ready_v[0] = 1'b1;
        bi = hs_q.size(); bd = done_q.size(); s = cyc;
        pulse_start0();
        wait_done0(40);
        @(negedge clk);
        check("sw_count", hs_q.size() - bi, 4);
        for (int k = 0; k < 4; k++) begin
            if (bi + k < hs_q.size()) begin
                check($sformatf("sw_data%0d", k), hs_q[bi+k].data, 32'hA500_0000 + k);
                check($sformatf("sw_addr%0d", k), hs_q[bi+k].addr, 4 * k);
                check($sformatf("sw_last%0d", k), hs_q[bi+k].last, k == 3);
                check($sformatf("sw_cyc%0d", k), hs_q[bi+k].cyc - s, 3 + 3 * k);
            end
        end
        check("sw_done_count", done_q.size() - bd, 1);
        if (done_q.size() > bd) check("sw_done_cyc", done_q[bd] - s, 13);

        // Stall word 2 for 5 cycles
        bi = hs_q.size();
        pulse_start0();
        wait_word0(32'h8, 40);
        ready_v[0] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", valid_v[0], 1'b1);
            check("stall_data", data_v[0], 32'hA500_0002);
            check("stall_addr", oaddr_v[0], 32'h8);
            check("stall_mem", mem_addr_v[0], 32'h8);
        end
        ready_v[0] = 1'b1;
        wait_done0(40);
        @(negedge clk);
        check("stall_count", hs_q.size() - bi, 4);
        for (int k = 0; k < 4; k++) begin
            if (bi + k < hs_q.size()) check($sformatf("stall_seq%0d", k), hs_q[bi+k].addr, 4 * k);
        end

        // Abort while word 1 is waiting in SEND
        pulse_start0();
        wait_word0(32'h4, 40);
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        check("ab_valid", valid_v[0], 1'b0);
        check("ab_busy", busy_v[0], 1'b0);
        check("ab_done", done_v[0], 1'b0);
        check("ab_last", last_v[0], 1'b0);
        bd = done_q.size();
        repeat (6) @(negedge clk);
        check("ab_no_done", done_q.size() - bd, 0);
        bi = hs_q.size();
        pulse_start0();
        wait_done0(40);
        @(negedge clk);
        check("ab_restart_count", hs_q.size() - bi, 4);
        if (hs_q.size() > bi) check("ab_restart_addr", hs_q[bi].addr, 32'h0);

        // start held for 40 cycles: sweeps start 13 cycles apart, 4 in total
        bd = done_q.size(); s = cyc;
        start_v[0] = 1'b1;
        repeat (40) @(negedge clk);
        start_v[0] = 1'b0;
        n = 0;
        while ((busy_v[0] || done_v[0]) && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("held_done_count", done_q.size() - bd, 4);
        if (done_q.size() > bd + 1) begin
            check("held_first_done", done_q[bd] - s, 13);
            check("held_gap", done_q[bd+1] - done_q[bd], 13);
        end

        // Randomized traffic on the small instance
        for (int i = 0; i < 1500; i++) begin
            start_v[0] = ($urandom_range(0, 7) == 0);
            abort_v[0] = ($urandom_range(0, 39) == 0);
            ready_v[0] = ($urandom_range(0, 9) < 7);
            @(negedge clk);
        end
        start_v[0] = 1'b0;
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        ready_v[0] = 1'b1;

        // Let the 1024-word sweep finish
        n = 0;
        while (big_done == 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("big_done", big_done, 1);
        check("big_count", big_hs, 1024);
        check("big_last_addr", big_last_addr, 32'hFFC);
        check("big_last_flag", big_last_last, 1'b1);

        // Reset asserted in the CAPT cycle: outputs clear without a clock edge
        pulse_start0();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset(0);
        check_reset(1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_busy", busy_v[0], 1'b0);
        check("post_rst_valid", valid_v[0], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rom_word_reader.md
# rom_word_reader

Sequential reader that walks the synchronous 32-bit program ROM from a base byte address, one word at a time. It drives the ROM's byte address and captures the read data one cycle later. Each word is presented, with its byte address, on a valid/ready output stream toward the hex-dump/UART path. It sits between `prx32_memory` (addr in, rdata out, 1-cycle latency) and the board-level dump logic, and is controlled by a start/abort pair.

## Interface
- `NUM_WORDS`, 1024, number of words per sweep; legal range 1..1024.
- `BASE_ADDR`, 32'h0000_0000, byte address of the first word; must be 4-byte aligned.
- `clk` in 1: single clock. Every register is clocked on `posedge clk`.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: pulse or level. Sampled only in IDLE.
- `abort` in 1: synchronous cancel. Has priority over every other input.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last word's handshake.
- `mem_addr` out 32: registered byte address to the ROM.
- `mem_rdata` in 32: ROM read data, valid the cycle after `mem_addr` is sampled.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: downstream accept.
- `out_data` out 32: captured ROM word.
- `out_addr` out 32: byte address of `out_data`.
- `out_last` out 1: high with the final word of a sweep.

## Operation
- FSM states: IDLE, ISSUE, CAPT, SEND.
- IDLE: `start`=1 → `mem_addr`<=BASE_ADDR, word count<=0, go to ISSUE.
- ISSUE: `mem_addr` is stable, and the ROM samples it on this edge. Go to CAPT.
- CAPT: `mem_rdata` is valid. `out_data`<=`mem_rdata`, `out_addr`<=`mem_addr`, `out_valid`<=1, `out_last`<=(count==NUM_WORDS-1). Go to SEND.
- SEND: hold all outputs stable until `out_valid`&&`out_ready`. On the handshake, `out_valid`<=0, then:
  - If last: `done`<=1 for one cycle, go to IDLE.
  - Else: `mem_addr`<=`mem_addr`+4, count+1, go to ISSUE.
- `abort`=1 in any state → IDLE next edge:
  - `out_valid`, `out_last` <=0; no `done` pulse; `mem_addr` keeps its value.
  - `abort` overrides the stream hold rule.
- `start` outside IDLE is ignored. `start` with `abort` in IDLE → stay IDLE.
- Address arithmetic is 32-bit modulo 2^32. The word counter is $clog2(NUM_WORDS+1) bits wide. The low 2 bits of `mem_addr` are always 0.
- `out_data`/`out_addr` keep their last values after the handshake; they are don't-care while `out_valid`=0.
- The block has no write path and never modifies the ROM.

## Timing
- Reset values (async assert, sync-safe deassert):
  - State IDLE.
  - `busy`=0, `done`=0, `out_valid`=0, `out_last`=0.
  - `out_data`=0, `out_addr`=0, `mem_addr`=BASE_ADDR, count=0.
- `start` sampled at edge E:
  - `busy`=1 and `mem_addr`=BASE_ADDR after E.
  - `out_valid`=1 after E+2.
- Per word, with `out_ready` held high: 3 cycles (ISSUE, CAPT, SEND). A full sweep takes 3·NUM_WORDS cycles from start to the last handshake.
- `done` is high for exactly the one cycle after the final handshake edge, with `busy`=0 in that same cycle. A `start` in that cycle is accepted.
- `out_ready` may be low indefinitely; the FSM stalls in SEND with outputs stable.
- Reset mid-sweep returns all outputs to their reset values immediately, with no `done`.

## Test plan
- ROM image with word i = 32'hA500_0000+i, NUM_WORDS=4, `out_ready`=1, pulse `start`:
  - Words A5000000..A5000003 appear at addrs 0,4,8,C.
  - `out_valid` first at start+2, next word every 3 cycles.
  - `out_last` only on addr C; `done` one cycle later.
- Same sweep with `out_ready` low for 5 cycles on word 2:
  - `out_data`=A5000002 and `out_addr`=8 held stable.
  - `mem_addr` does not advance.
  - Sweep completes with all 4 words, no duplicates, no drops.
- Assert `abort` in SEND of word 1:
  - Next cycle `out_valid`=0, `busy`=0, no `done`.
  - A following `start` restarts at addr 0.
- NUM_WORDS=1024: the last word has `out_addr`=0xFFC and `out_last`=1. No ROM out-of-range warning fires during the sweep.
- `start` held high continuously:
  - Back-to-back sweeps; `done` pulses between them.
  - `start` ignored while `busy`=1.
- Drop `rst_n` during CAPT: all outputs go to their reset values without a clock edge. After release, IDLE is held until `start`.
